enable_gen: RTL and testbench

Programmable enable-pulse generator that drives the `enable` input of `counter_with_enable`. A prescaler turns the clock into single-cycle enable pulses every `div+1` cycles. It runs either continuously until stopped or for a fixed burst of pulses, so the counter downstream advances at a controlled rate and by a controlled amount.

---
 rtl/enable_gen_pkg.sv | 13 +
 rtl/enable_gen_prescaler.sv | 34 +++
 rtl/enable_gen.sv | 108 ++++++++++
 tb/tb_enable_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enable_gen_pkg.sv
// Shared types and constants for the enable_gen pulse generator.
package enable_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enable_gen_state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/enable_gen_prescaler.sv
// Loadable prescaler: holds the terminal value and counts 0..div_q, wrapping to 0.
// A load both latches the new terminal value and clears the count.
module enable_gen_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_div,
  input  logic                 count_en,
  output logic                 tc
);

  localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] count_reg;
  logic [DIV_WIDTH-1:0] div_reg;

  assign tc = (count_reg == div_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      div_reg   <= '0;
    end else if (load) begin
      count_reg <= '0;
      div_reg   <= load_div;
    end else if (count_en) begin
      // Explicit wrap on terminal so an all-ones div never relies on overflow.
      count_reg <= tc ? '0 : count_reg + ONE;
    end
  end

endmodule

// File: rtl/enable_gen.sv
// Enable-pulse generator: one-cycle pulse every div+1 cycles, continuous or burst.
// Burst mode and the DONE state exist only when ENABLE_GEN_BURST_EN is defined.
module enable_gen
  import enable_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   enable,
  output logic                   busy,
  output logic                   done
);

  enable_gen_state_t state_reg;
  logic              enable_reg;
  logic              start_ok;
  logic              presc_tc;

  assign start_ok = (state_reg == IDLE) && start && !stop;

  enable_gen_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .load     (start_ok),
    .load_div (div),
    .count_en (state_reg == RUN),
    .tc       (presc_tc)
  );

`ifdef ENABLE_GEN_BURST_EN
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

  logic                   mode_reg;
  logic [BURST_WIDTH-1:0] burst_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      enable_reg    <= 1'b0;
      mode_reg      <= MODE_CONT;
      burst_cnt_reg <= '0;
    end else begin
      enable_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            mode_reg      <= mode;
            burst_cnt_reg <= burst_len;
            // An empty burst completes immediately without touching RUN.
            if (mode == MODE_BURST && burst_len == '0) state_reg <= DONE;
            else                                       state_reg <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= IDLE;
          end else if (presc_tc) begin
            enable_reg <= 1'b1;
            if (mode_reg == MODE_BURST) begin
              burst_cnt_reg <= burst_cnt_reg - BURST_ONE;
              if (burst_cnt_reg == BURST_ONE) state_reg <= DONE;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign done = (state_reg == DONE);
`else
  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{mode, burst_len};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      enable_reg <= 1'b0;
    end else begin
      enable_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start_ok) state_reg <= RUN;
        RUN: begin
          if (stop)          state_reg  <= IDLE;
          else if (presc_tc) enable_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign done = 1'b0;
`endif

  assign enable = enable_reg;
  assign busy   = (state_reg == RUN);

endmodule

// File: tb/tb_enable_gen.sv
// Directed self-checking bench for enable_gen; burst scenarios follow ENABLE_GEN_BURST_EN.
module tb_enable_gen;

  localparam int DW = 8;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] div = '0;
  logic [BW-1:0] burst_len = '0;
  logic          enable;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  enable_gen #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .div       (div),
    .burst_len (burst_len),
    .enable    (enable),
    .busy      (busy),
    .done      (done)
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({enable, busy, done} !== 3'b000)
      $display("FAIL reset_outputs: got %b expected 000", {enable, busy, done});
    else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({enable, busy, done} !== 3'b000)
      $display("FAIL post_reset_idle: got %b expected 000", {enable, busy, done});
    else n_pass++;
  endtask

  // div=3: pulses 4 cycles after start and every 4 after; stop on a terminal edge.
  task automatic test_continuous();
    int pulses = 0;
    div = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || enable !== 1'b0)
      $display("FAIL cont_start: busy=%b enable=%b expected busy=1 enable=0", busy, enable);
    else n_pass++;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (enable === 1'b1) pulses++;
      n_checks++;
      if (enable !== (i % 4 == 0) || done !== 1'b0)
        $display("FAIL cont_pulse_c%0d: enable=%b done=%b expected enable=%b done=0",
                 i, enable, done, (i % 4 == 0));
      else n_pass++;
    end
    n_checks++;
    if (pulses != 5) $display("FAIL cont_count20: got %0d expected 5", pulses);
    else n_pass++;
    repeat (3) tick();
    stop = 1'b1;   // sampled on the next edge, where the prescaler is terminal
    tick();
    stop = 1'b0;
    n_checks++;
    if (enable !== 1'b0 || busy !== 1'b0)
      $display("FAIL stop_on_terminal: enable=%b busy=%b expected 0 0", enable, busy);
    else n_pass++;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (enable === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL cont_after_stop: got %0d pulses expected 0", pulses);
    else n_pass++;
  endtask

  task automatic test_start_stop_idle();
    int pulses = 0;
    div = 8'd0; mode = 1'b0; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL start_stop_idle: busy=%b expected 0", busy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (enable === 1'b1 || busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL start_stop_idle_quiet: got %0d active cycles expected 0", pulses);
    else n_pass++;
  endtask

  // start (with a new div) during RUN must not restart or retime the run.
  task automatic test_start_during_run();
    int errs = 0;
    div = 8'd2; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) begin start = 1'b1; div = 8'd0; end
      tick();
      start = 1'b0;
      if (enable !== (i % 3 == 0) || busy !== 1'b1) errs++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL start_in_run_period: %0d bad cycles expected 0", errs);
    else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    div = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (enable !== 1'b1 || busy !== 1'b1)
      $display("FAIL rst_run_pre: enable=%b busy=%b expected 1 1", enable, busy);
    else n_pass++;
    #2 reset = 1'b0;
    #1;   // still well before the next rising edge
    n_checks++;
    if ({enable, busy, done} !== 3'b000)
      $display("FAIL rst_async_clear: got %b expected 000", {enable, busy, done});
    else n_pass++;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enable === 1'b1 || busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL rst_no_resume: got %0d active cycles expected 0", pulses);
    else n_pass++;
  endtask

`ifdef ENABLE_GEN_BURST_EN
  // div=0, len=5: enable on cycles 1..5, done on 5, busy 0..4; then back-to-back start.
  task automatic test_burst();
    int pulses = 0;
    int busy_en = 0;
    div = 8'd0; mode = 1'b1; burst_len = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || enable !== 1'b0)
      $display("FAIL burst_start: busy=%b enable=%b expected 1 0", busy, enable);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (enable === 1'b1) pulses++;
      if (enable === 1'b1 && busy === 1'b1) busy_en++;
      n_checks++;
      if (enable !== 1'b1 || done !== (i == 5) || busy !== (i < 5))
        $display("FAIL burst_c%0d: en=%b done=%b busy=%b expected 1 %b %b",
                 i, enable, done, busy, (i == 5), (i < 5));
      else n_pass++;
    end
    n_checks++;
    if (pulses != 5 || busy_en != 4)
      $display("FAIL burst_totals: pulses=%0d busy_with_enable=%0d expected 5 4", pulses, busy_en);
    else n_pass++;
    // start held through the DONE cycle: ignored there, accepted in first IDLE cycle.
    div = 8'd1; burst_len = 8'd2; start = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || enable !== 1'b0)
      $display("FAIL burst_done_ignores_start: busy=%b done=%b en=%b expected 0 0 0",
               busy, done, enable);
    else n_pass++;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL back_to_back_start: busy=%b expected 1", busy);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (enable !== (i == 2 || i == 4) || done !== (i == 4))
        $display("FAIL b2b_c%0d: en=%b done=%b expected %b %b",
                 i, enable, done, (i == 2 || i == 4), (i == 4));
      else n_pass++;
    end
  endtask

  task automatic test_burst_zero();
    int active = 0;
    div = 8'd0; mode = 1'b1; burst_len = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || enable !== 1'b0)
      $display("FAIL burst0_done: done=%b busy=%b en=%b expected 1 0 0", done, busy, enable);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (enable === 1'b1 || busy === 1'b1 || done === 1'b1) active++;
    end
    n_checks++;
    if (active != 0) $display("FAIL burst0_quiet: got %0d active cycles expected 0", active);
    else n_pass++;
  endtask
`else
  // Without burst support, mode=1/len=2 still runs continuously.
  task automatic test_no_burst_build();
    int pulses = 0;
    int dones = 0;
    div = 8'd1; mode = 1'b1; burst_len = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (enable === 1'b1) pulses++;
      if (done !== 1'b0) dones++;
    end
    n_checks++;
    if (pulses != 5) $display("FAIL nob_pulses: got %0d expected 5", pulses);
    else n_pass++;
    n_checks++;
    if (dones != 0) $display("FAIL nob_done: got %0d done cycles expected 0", dones);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL nob_busy: got %b expected 1", busy);
    else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_start_stop_idle();
    test_start_during_run();
    test_reset_mid_run();
`ifdef ENABLE_GEN_BURST_EN
    test_burst();
    test_burst_zero();
`else
    test_no_burst_build();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
